decouple_lvl: RTL
=================

Name: decouple_lvl

Overview:
- Parametrised successor to the basic DTI decoupling buffer.
- Breaks the combinational valid/ready/data path between a dti producer and a dti consumer, using a circular buffer of any DEPTH ≥ 1 (not restricted to powers of two).
- Adds a synchronous flush, an occupancy output and a programmable almost-full flag.
- Sits on DTI links wherever back-pressure monitoring or pipeline draining is needed, e.g. in front of rate-adapting or drop logic.

Parameters:
- DEPTH, 2: number of storage entries; any integer ≥ 1.
- DIN, 16: data width in bits.
- INIT, 0: value preloaded into entry 0 on reset when INIT_VALID=1.
- INIT_VALID, 0: 1 means the buffer comes out of reset holding one word equal to INIT.
- AF_THRESH, DEPTH: almost_full asserts when level ≥ AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous discard of all stored words.
- din  dti.consumer  DIN  input data interface; carries data, valid, ready.
- dout  dti.producer  DIN  output data interface; carries data, valid, ready.
- level  output  CW=$clog2(DEPTH+1)  current number of stored words.
- almost_full  output  1  high when level ≥ AF_THRESH.

Behaviour:

State and pointers:
- State consists of mem[0..DEPTH-1], w_ptr and r_ptr (each 0..DEPTH-1, width max(1,$clog2(DEPTH))), and cnt (0..DEPTH, width CW).
- Pointer increment wraps explicitly: value DEPTH-1 goes to 0. No binary roll-over is relied on, so non-power-of-two depths are legal.

Combinational outputs:
- din.ready = (cnt < DEPTH) & ~flush. It does not depend on dout.ready; there is no same-cycle pass-through when full.
- dout.valid = (cnt != 0) & ~flush.
- dout.data = mem[r_ptr].
- level = cnt.
- almost_full = (cnt ≥ AF_THRESH).

Handshakes:
- Write event wr = din.valid & din.ready: mem[w_ptr] ← din.data, and w_ptr advances.
- Read event rd = dout.valid & dout.ready: r_ptr advances.
- cnt update:
  - +1 on wr only.
  - −1 on rd only.
  - unchanged on both or neither.
- When full, din.ready is low, so no write occurs even if a read happens that cycle.
- When empty, dout.valid is low, so no read occurs.
- dout.valid and dout.data stay stable while dout.valid=1 and dout.ready=0.

Latency and throughput:
- A word accepted at edge N is visible on dout from cycle N+1, i.e. one cycle of latency.
- For DEPTH ≥ 2, sustained throughput is one word per cycle with dout.ready held high.
- For DEPTH = 1, throughput is one word every 2 cycles (write blocked while full).

Flush:
- While flush is high, no handshake can complete, because both din.ready and dout.valid are forced low.
- At the edge with flush=1: cnt ← 0, w_ptr ← 0, r_ptr ← 0.
- mem contents are don't-care after flush.
- Flush does not reload INIT.

Reset (priority over flush):
- If INIT_VALID=0:
  - cnt=0, w_ptr=0, r_ptr=0.
  - Outputs after reset: dout.valid=0, din.ready=1, level=0, almost_full=(AF_THRESH≤0)=0.
- If INIT_VALID=1:
  - mem[0]=INIT, cnt=1, r_ptr=0, w_ptr=(1 mod DEPTH).
  - Outputs after reset: dout.valid=1, dout.data=INIT, level=1, almost_full=(AF_THRESH==1).
  - din.ready=0 if DEPTH=1.
- Reset mid-operation discards all contents in one cycle.
- No handshake is reported complete on a cycle where rst=1; dout.valid and din.ready are treated as don't-care during rst.

Wrap-around:
- Ordering is strictly FIFO across pointer wrap for every DEPTH.
- Write and read pointers may be equal with cnt = 0 (empty) or cnt = DEPTH (full); cnt alone distinguishes the two cases.

Test Plan:
1. DEPTH=3, DIN=8, dout.ready=0: push 0x11, 0x22, 0x33, 0x44 → first three accepted, din.ready low on the 4th, level=3, almost_full=1; then ready=1 → out 0x11, 0x22, 0x33 on consecutive cycles, then 0x44 after it is accepted.
2. DEPTH=5, both sides always ready, 20 incrementing words 0..19 → output 0..19 in order with 1-cycle latency, no gaps; pointers wrap 4 times; level stays at 1 during steady state.
3. DEPTH=1: valid held high, data 1..4, ready=1 → outputs 1..4 at one word per 2 cycles; din.ready toggles 1,0,1,0.
4. DEPTH=4, AF_THRESH=3: fill 3 words, assert flush for 1 cycle with din.valid=1 → din.ready=0 and dout.valid=0 during flush, level=0 next cycle, almost_full drops, then the next pushed word 0xAB appears first.
5. INIT_VALID=1, INIT=0x5A, DEPTH=2: release reset → dout.valid=1 with data 0x5A, level=1; push 0x01 with dout.ready=0 → level=2, din.ready=0; consume → 0x5A then 0x01.
6. DEPTH=4: with 2 words stored, a simultaneous read and write over 10 cycles → level constant at 2, order preserved; assert rst mid-stream → level=0 and dout.valid=0 on the following cycle.

Source files
------------

// File: rtl/decouple_lvl.sv
// -----------------------------------------------------------------------------
// decouple_lvl
//
// Decoupling buffer for a DTI link. A circular buffer of DEPTH entries
// (any DEPTH >= 1, not restricted to powers of two) breaks the combinational
// valid/ready/data path between producer and consumer. It also provides a
// synchronous flush, an occupancy count and a programmable almost-full flag.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (priority over flush)
//   flush        synchronous discard of every stored word
//   din_data     input side data          (DTI consumer side)
//   din_valid    input side valid
//   din_ready    input side ready: space available and not flushing
//   dout_data    output side data, head of the buffer (DTI producer side)
//   dout_valid   output side valid: buffer not empty and not flushing
//   dout_ready   output side ready from the downstream consumer
//   level        number of stored words, 0..DEPTH
//   almost_full  high when level >= AF_THRESH
// -----------------------------------------------------------------------------
module decouple_lvl #(
   parameter int            DEPTH      = 2,
   parameter int            DIN        = 16,
   parameter logic [DIN-1:0] INIT      = '0,
   parameter int            INIT_VALID = 0,
   parameter int            AF_THRESH  = DEPTH,
   localparam int           CW         = $clog2(DEPTH + 1),
   localparam int           PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic [DIN-1:0] din_data,
   input  logic           din_valid,
   output logic           din_ready,
   output logic [DIN-1:0] dout_data,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic [CW-1:0]  level,
   output logic           almost_full
);

   logic [DIN-1:0] mem_q [DEPTH];
   logic [DIN-1:0] mem_d [DEPTH];
   logic [PW-1:0]  w_ptr_q, w_ptr_d;
   logic [PW-1:0]  r_ptr_q, r_ptr_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic           wr_s;
   logic           rd_s;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Handshake-visible outputs; both sides are blocked while flushing.
   always_comb begin
      din_ready   = (cnt_q < CW'(DEPTH)) & ~flush;
      dout_valid  = (cnt_q != {CW{1'b0}}) & ~flush;
      dout_data   = mem_q[r_ptr_q];
      level       = cnt_q;
      almost_full = (cnt_q >= CW'(AF_THRESH));
      wr_s        = din_valid & din_ready;
      rd_s        = dout_valid & dout_ready;
   end

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      cnt_d   = cnt_q;
      if (flush) begin
         w_ptr_d = {PW{1'b0}};
         r_ptr_d = {PW{1'b0}};
         cnt_d   = {CW{1'b0}};
      end else begin
         if (wr_s) begin
            mem_d[w_ptr_q] = din_data;
            w_ptr_d        = ptr_inc(w_ptr_q);
         end else begin
            w_ptr_d = w_ptr_q;
         end
         if (rd_s) begin
            r_ptr_d = ptr_inc(r_ptr_q);
         end else begin
            r_ptr_d = r_ptr_q;
         end
         // Simultaneous read and write leaves the count unchanged.
         case ({wr_s, rd_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State register; reset optionally comes up holding one INIT word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr_q <= {PW{1'b0}};
         if (INIT_VALID != 0) begin
            mem_q[0] <= INIT;
            cnt_q    <= CW'(1);
            w_ptr_q  <= PW'(1 % DEPTH);
         end else begin
            cnt_q    <= {CW{1'b0}};
            w_ptr_q  <= {PW{1'b0}};
         end
      end else begin
         mem_q   <= mem_d;
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
